float_div_arbiter: RTL

//  Shares one FloatingDivide instance among NUM_REQ requesters (e.g. shader lanes, CPU FPU port).

---
 rtl/float_div_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/float_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : float_div_arbiter
// Description : Round-robin sharing of one external FloatingDivide among
//               NUM_REQ requesters; a tag pipeline routes quotients back.
//               Optional FLOAT_DIV_ARB_DBZ_EN forces signed infinity on
//               divide-by-zero slots.
// Revision    : 1.0 - initial release
// ============================================================================
module float_div_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            div_a,
    output logic [31:0]            div_b,
    input  logic [31:0]            div_out,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data
);

    localparam int c_PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int c_DEPTH = DIV_LATENCY + 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [NUM_REQ-1:0] r_busy;
    logic [31:0]        r_divA;
    logic [31:0]        r_divB;
    logic [NUM_REQ-1:0] r_respValid;
    logic [31:0]        r_respData;

    logic               r_tagValid [c_DEPTH];
    logic [c_PTR_W-1:0] r_tagIdx   [c_DEPTH];
`ifdef FLOAT_DIV_ARB_DBZ_EN
    logic               r_tagDbz   [c_DEPTH];
    logic               r_tagSign  [c_DEPTH];
    logic               w_dbz;
    logic               w_sign;
`endif

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_PTR_W-1:0] w_grantIdx;
    logic [c_PTR_W-1:0] w_ptrNext;
    logic               w_accept;
    logic [31:0]        w_selA;
    logic [31:0]        w_selB;

    // Scan starts at the pointer and wraps; the first eligible index wins.
    always_comb begin : p_grant
        int j;
        j          = 0;
        w_elig     = req_valid & ~r_busy;
        w_grant    = '0;
        w_grantIdx = '0;
        w_accept   = 1'b0;
        w_selA     = '0;
        w_selB     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_accept && w_elig[j]) begin
                w_accept   = 1'b1;
                w_grant[j] = 1'b1;
                w_grantIdx = c_PTR_W'(j);
                w_selA     = req_a[32*j +: 32];
                w_selB     = req_b[32*j +: 32];
            end
        end
    end

    assign w_ptrNext = (w_grantIdx == c_PTR_W'(NUM_REQ-1)) ? '0 : w_grantIdx + 1'b1;

`ifdef FLOAT_DIV_ARB_DBZ_EN
    assign w_dbz  = (w_selB[30:0] == 31'd0);
    assign w_sign = w_selA[31] ^ w_selB[31];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_busy      <= '0;
            r_divA      <= '0;
            r_divB      <= '0;
            r_respValid <= '0;
            r_respData  <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_tagValid[i] <= 1'b0;
                r_tagIdx[i]   <= '0;
`ifdef FLOAT_DIV_ARB_DBZ_EN
                r_tagDbz[i]   <= 1'b0;
                r_tagSign[i]  <= 1'b0;
`endif
            end
        end else begin
            if (w_accept) begin
                r_ptr  <= w_ptrNext;
                r_divA <= w_selA;
                r_divB <= w_selB;
            end
            // busy drops at the end of the response cycle, so re-grant lands one cycle later
            r_busy <= (r_busy & ~r_respValid) | (w_accept ? w_grant : '0);

            r_tagValid[0] <= w_accept;
            r_tagIdx[0]   <= w_grantIdx;
`ifdef FLOAT_DIV_ARB_DBZ_EN
            r_tagDbz[0]   <= w_accept & w_dbz;
            r_tagSign[0]  <= w_sign;
`endif
            for (int i = 1; i < c_DEPTH; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagIdx[i]   <= r_tagIdx[i-1];
`ifdef FLOAT_DIV_ARB_DBZ_EN
                r_tagDbz[i]   <= r_tagDbz[i-1];
                r_tagSign[i]  <= r_tagSign[i-1];
`endif
            end

            r_respValid <= '0;
            if (r_tagValid[c_DEPTH-1]) begin
                r_respValid[r_tagIdx[c_DEPTH-1]] <= 1'b1;
`ifdef FLOAT_DIV_ARB_DBZ_EN
                r_respData <= r_tagDbz[c_DEPTH-1] ?
                              {r_tagSign[c_DEPTH-1], 8'hFF, 23'h0} : div_out;
`else
                r_respData <= div_out;
`endif
            end
        end
    end

    assign req_ready  = rst ? '0 : w_grant;
    assign div_a      = r_divA;
    assign div_b      = r_divB;
    assign resp_valid = r_respValid;
    assign resp_data  = r_respData;

endmodule
`default_nettype wire
